// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program image as a valid/ready stream of DATA_W-bit words, writes it into
//   instruction memory and sequences the core: cpu_rst is held high while loading and for
//   RST_HOLD cycles after the last write, then released together with a one-cycle cpu_start.
//   Stream format: one header word (low ADDR_W bits = base address), then payload words,
//   the final one tagged with s_last.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   load_req                 start (or restart) a load; honoured only when idle or running
//   s_valid/s_data/s_last    image stream in; s_ready is registered
//   imem_we/addr/wdata       instruction-memory write port, one cycle after each transfer
//   cpu_rst, cpu_start       core reset and start pulse
//   busy, done               loading in progress / image loaded and core running (sticky)
//   err_overflow             payload ran past the top of memory (sticky)
//   err_checksum             checksum mismatch (sticky), 0 unless checksum build
//   word_count               payload words written in the current load
//
// Build option: define LOADER_CHECKSUM_EN to treat the s_last word as an XOR checksum over
// the written payload; the checksum word is then neither written nor counted.
module imem_boot_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_checksum,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StLoad = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StRun  = 3'd4;

  localparam logic [ADDR_W-1:0] AddrMax  = '1;
  localparam logic [3:0]        HoldLast = 4'(RST_HOLD - 1);

  logic [2:0]        state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrote_top_q, wrote_top_d;
  logic [3:0]        hold_q, hold_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              cpu_start_q, cpu_start_d;
  logic              done_q, done_d;
  logic              err_ovf_q, err_ovf_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;

  logic xfer, start_load, csum_word, csum_ok, wr_word, ovf_hit;

  assign xfer       = s_valid & s_ready_q;
  assign start_load = load_req & ((state_q == StIdle) | (state_q == StRun));

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_csum_q, err_csum_d;

  assign csum_word = s_last;
  assign csum_ok   = (s_data == csum_q);

  always_comb begin
    csum_d     = csum_q;
    err_csum_d = err_csum_q;
    if (start_load) begin
      csum_d     = '0;
      err_csum_d = 1'b0;
    end else if (wr_word) begin
      csum_d = csum_q ^ s_data;
    end
    if ((state_q == StLoad) && xfer && s_last && !csum_ok) begin
      err_csum_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q     <= '0;
      err_csum_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      err_csum_q <= err_csum_d;
    end
  end

  assign err_checksum = err_csum_q;
`else
  assign csum_word    = 1'b0;
  assign csum_ok      = 1'b1;
  assign err_checksum = 1'b0;
`endif

  // Once the top word has been written, later payload words are swallowed, not written.
  assign wr_word = (state_q == StLoad) & xfer & ~csum_word & ~wrote_top_q;
  assign ovf_hit = (state_q == StLoad) & xfer & ~csum_word & wrote_top_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wrote_top_d  = wrote_top_q;
    hold_d       = hold_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_start_d  = 1'b0;
    done_d       = done_q;
    err_ovf_d    = err_ovf_q;
    wcnt_d       = wcnt_q;

    if (start_load) begin
      state_d   = StHdr;
      done_d    = 1'b0;
      err_ovf_d = 1'b0;
      wcnt_d    = '0;
    end

    if (wr_word) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = addr_q;
      imem_wdata_d = s_data;
      wcnt_d       = wcnt_q + 1'b1;
      // Address saturates at the top; the flag remembers that the top slot is used.
      if (addr_q == AddrMax) begin
        wrote_top_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    if (ovf_hit) begin
      err_ovf_d = 1'b1;
    end

    case (state_q)
      StHdr: begin
        if (xfer) begin
          addr_d      = s_data[ADDR_W-1:0];
          wrote_top_d = 1'b0;
          hold_d      = '0;
          state_d     = s_last ? StHold : StLoad;
        end
      end
      StLoad: begin
        if (xfer && s_last) begin
          hold_d  = '0;
          state_d = csum_ok ? StHold : StIdle;
        end
      end
      StHold: begin
        // The trailing write cycle does not count toward the hold time.
        if (!imem_we_q) begin
          if (hold_q == HoldLast) begin
            state_d     = StRun;
            done_d      = 1'b1;
            cpu_start_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    s_ready_d = (state_d == StHdr) | (state_d == StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      s_ready_q    <= 1'b0;
      addr_q       <= '0;
      wrote_top_q  <= 1'b0;
      hold_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_start_q  <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      addr_q       <= addr_d;
      wrote_top_q  <= wrote_top_d;
      hold_q       <= hold_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_start_q  <= cpu_start_d;
      done_q       <= done_d;
      err_ovf_q    <= err_ovf_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst      = (state_q != StRun);
  assign cpu_start    = cpu_start_q;
  assign busy         = (state_q == StHdr) | (state_q == StLoad) | (state_q == StHold);
  assign done         = done_q;
  assign err_overflow = err_ovf_q;
  assign word_count   = wcnt_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream companion of the 5-stage pipeline core. Receives a program image as a stream of 16-bit words over a valid/ready handshake and writes it into instruction memory. Holds the core in reset during loading. On completion it releases the core's reset and pulses the core's start input, so the IF stage begins fetching a fully loaded image.

Parameters:
ADDR_W, 12, instruction-memory word-address width; memory depth is 2^ADDR_W words.
DATA_W, 16, instruction word width; fixed by the ISA.
RST_HOLD, 2, cycles cpu_rst stays high after the last write before release; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
load_req  in  1  one-cycle request to start a load; honoured in IDLE or RUN only
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_last  in  1  marks final word of the image
s_ready  out  1  loader accepts the word this cycle
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_W  instruction-memory write address
imem_wdata  out  DATA_W  instruction-memory write data
cpu_rst  out  1  reset to the processor core
cpu_start  out  1  one-cycle start pulse to the core
busy  out  1  high in HDR, LOAD, HOLD
done  out  1  sticky; set on entering RUN, cleared on accepted load_req
err_overflow  out  1  sticky; write address ran past 2^ADDR_W-1
err_checksum  out  1  sticky; see Optional Feature, otherwise constant 0
word_count  out  ADDR_W+1  payload words written in the current load

Behaviour:
- Reset values:
  - cpu_rst=1.
  - All other outputs 0.
  - State IDLE.
  - Internal base/address registers 0.
- Handshake:
  - A word transfers on a cycle where s_valid and s_ready are both high.
  - s_ready=1 only in HDR and LOAD, and it is a registered output.
  - s_data and s_last are sampled only on a transfer.
- States:
  - IDLE: cpu_rst=1. load_req moves to HDR and clears done, err_*, and word_count.
  - HDR: the first transfer is the header. s_data[ADDR_W-1:0] becomes the base address; upper bits are ignored.
    - Header with s_last=1 means an empty image: go to HOLD with word_count=0.
    - Otherwise go to LOAD.
  - LOAD: each transfer is a payload word.
    - One cycle after the transfer: imem_we=1, imem_addr=current address, imem_wdata=word.
    - Address then increments by 1 and word_count increments by 1.
    - s_last on a transfer moves to HOLD after the final write is issued.
  - HOLD: cpu_rst=1 for RST_HOLD cycles, counted from the cycle after the last imem_we. Then go to RUN.
  - RUN:
    - cpu_rst=0 from the first RUN cycle.
    - cpu_start=1 for exactly the first RUN cycle only.
    - done=1.
    - load_req returns to HDR with cpu_rst=1 the next cycle. This is a reload; the core is re-reset.
- load_req in HDR, LOAD, or HOLD is ignored.
- Overflow:
  - A payload transfer while the address is already 2^ADDR_W-1 and a previous write went there sets err_overflow.
  - Further words are still accepted (s_ready stays 1) but are not written (imem_we=0) and are not counted, until s_last.
  - The load still completes to RUN.
  - The address register never wraps to 0.
- word_count does not wrap. Its maximum is 2^ADDR_W.
- imem_we is never asserted outside LOAD plus the one trailing cycle.
- rst mid-load:
  - Immediately IDLE with cpu_rst=1 and imem_we=0.
  - A partially written memory is not cleaned up.
- s_valid low inside LOAD: wait indefinitely, with no timeout.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 16-bit XOR is kept over all written payload words. It is cleared on HDR entry.
  - The word tagged s_last is the checksum word. It is not written and not counted.
  - On mismatch, set err_checksum=1 and go to IDLE instead of HOLD. The core stays in reset.
  - A header with s_last=1 is treated as an empty image with no checksum.
  - A payload of a single checksum word 0x0000 passes.
- Undefined:
  - The s_last word is an ordinary payload word that is written and counted.
  - err_checksum is tied 0.
  - The XOR logic is absent.

Test Plan:
- Reset, then no load_req for 20 cycles -> cpu_rst=1 throughout, imem_we=0, s_ready=0.
- load_req, header 0x0010, payload 0x1111, 0x2222, 0x3333 (last), s_valid always 1 -> writes addr 0x010/0x1111, 0x011/0x2222, 0x012/0x3333 on consecutive cycles. Then word_count=3, cpu_rst falls 2 cycles after the last write, and cpu_start pulses once. Checksum build: append 0x0000 as the last word -> err_checksum=0, same writes.
- Header 0xFFE (ADDR_W=12), payload 4 words -> writes at 0xFFE and 0xFFF only. err_overflow=1, word_count=2, s_ready stays 1 until last, then RUN.
- Random s_valid gaps of 0–5 cycles during a 64-word load -> 64 writes at sequential addresses; no duplicate or dropped words.
- From RUN, load_req, then rst asserted mid-payload after 3 words -> cpu_rst=1 the cycle after load_req and stays 1. After rst: IDLE, all outputs at reset values.
- LOADER_CHECKSUM_EN: payload 0x00FF, 0x0F0F, checksum 0x1234 -> err_checksum=1, state IDLE, cpu_start never pulses, cpu_rst=1.
